// File: rtl/instr_exec_ctrl_pkg.sv
// rtl/instr_exec_ctrl_pkg.sv - shared constants, opcode set and switch record for instr_exec_ctrl
//
// Purpose: instruction geometry, opcode encoding and the record that carries a
// pending thread switch from the decode cycle to the NEXT_THREAD cycle.
package instr_exec_ctrl_pkg;

  localparam int INSTR_LEN  = 16;
  localparam int IADDR_LEN  = 10;
  localparam int OPCODE_W   = 3;
  localparam int OPCODE_MSB = INSTR_LEN - 1;

  typedef enum logic [OPCODE_W-1:0] {
    OP_NOP    = 3'd0,
    OP_EXEC   = 3'd1,
    OP_SETCNT = 3'd2,
    OP_LOOP   = 3'd3,
    OP_JMP    = 3'd4,
    OP_YIELD  = 3'd5,
    OP_HALT   = 3'd6
  } opcode_e;

  // What the NEXT_THREAD cycle must present once the INVALIDATE cycle is over.
  typedef struct packed {
    logic                 jump;
    logic [IADDR_LEN-1:0] addr;
    logic                 executed;
    logic                 done;
  } switch_t;

  // Index of the most significant set bit needed to hold values 0..v.
  function automatic int msb_of(input int v);
    return (v <= 1) ? 0 : $clog2(v + 1) - 1;
  endfunction

endpackage

// File: rtl/instr_exec_ctrl_if.sv
// rtl/instr_exec_ctrl_if.sv - fetch-side bundle between instruction fetch and instr_exec_ctrl
//
// Purpose: groups the fetched-instruction inputs and the fetch control outputs.
// master: fetch stage (drives instruction, instr_valid, thread_num, core_rdy).
// slave : instr_exec_ctrl (drives INVALIDATE, INSTR_WAIT, EXECUTED, NEXT_THREAD,
//         JUMP, jump_addr, exec_valid, exec_op, thread_done, err).
interface instr_exec_ctrl_if #(
  parameter int N_THREADS_MSB = 3
);
  import instr_exec_ctrl_pkg::*;

  logic [INSTR_LEN-1:0]     instruction;
  logic                     instr_valid;
  logic [N_THREADS_MSB:0]   thread_num;
  logic                     core_rdy;

  logic                     INVALIDATE;
  logic                     INSTR_WAIT;
  logic                     EXECUTED;
  logic                     NEXT_THREAD;
  logic                     JUMP;
  logic [IADDR_LEN-1:0]     jump_addr;
  logic                     exec_valid;
  logic [INSTR_LEN-1:0]     exec_op;
  logic                     thread_done;
  logic                     err;

  modport master (
    output instruction, instr_valid, thread_num, core_rdy,
    input  INVALIDATE, INSTR_WAIT, EXECUTED, NEXT_THREAD, JUMP, jump_addr,
    input  exec_valid, exec_op, thread_done, err
  );

  modport slave (
    input  instruction, instr_valid, thread_num, core_rdy,
    output INVALIDATE, INSTR_WAIT, EXECUTED, NEXT_THREAD, JUMP, jump_addr,
    output exec_valid, exec_op, thread_done, err
  );

endinterface

// File: rtl/instr_exec_ctrl_thread_loop_cnt.sv
// rtl/instr_exec_ctrl_thread_loop_cnt.sv - per-thread loop counter RAM with set/decrement/zero flag
//
// Purpose: N_THREADS x CNT_WIDTH distributed RAM, asynchronous read, write on CLK.
// Ports:
//   CLK        clock
//   i_thread   thread whose counter is read and written
//   i_set      load i_set_val into the counter (wins over i_dec)
//   i_set_val  value to load
//   i_dec      decrement the counter (ignored when it is already zero)
//   o_zero     the addressed counter is zero
module thread_loop_cnt #(
  parameter int N_THREADS = 16,
  parameter int THREAD_W  = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic [THREAD_W-1:0]  i_thread,
  input  logic                 i_set,
  input  logic [CNT_WIDTH-1:0] i_set_val,
  input  logic                 i_dec,
  output logic                 o_zero
);

  // Contents survive reset on purpose: software reloads counters with SETCNT.
  logic [CNT_WIDTH-1:0] r_mem [N_THREADS];
  logic [CNT_WIDTH-1:0] w_rd;

  assign w_rd   = r_mem[i_thread];
  assign o_zero = (w_rd == '0);

  always_ff @(posedge CLK) begin
    if (i_set) begin
      r_mem[i_thread] <= i_set_val;
    end else if (i_dec && !o_zero) begin
      r_mem[i_thread] <= w_rd - CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/instr_exec_ctrl.sv
// rtl/instr_exec_ctrl.sv - instruction decode and fetch control stage of a sha512unit CPU
//
// Purpose: decodes each fetched instruction, issues compute ops to the core,
// runs per-thread loops and sequences thread switches / jumps for the fetch stage.
// Ports:
//   CLK      clock
//   RESET_N  synchronous active-low reset
//   bus      instr_exec_ctrl_if.slave: instruction/instr_valid/thread_num/core_rdy in;
//            INVALIDATE, INSTR_WAIT, EXECUTED, NEXT_THREAD, JUMP, jump_addr,
//            exec_valid, exec_op, thread_done, err out (all registered, latency 1)
module instr_exec_ctrl
  import instr_exec_ctrl_pkg::*;
#(
  parameter int N_CORES       = 4,
  parameter int N_THREADS     = 4 * N_CORES,
  parameter int N_THREADS_MSB = msb_of(N_THREADS - 1),
  parameter int CNT_WIDTH     = 8
) (
  input  logic               CLK,
  input  logic               RESET_N,
  instr_exec_ctrl_if.slave   bus
);

  localparam logic [1:0] S_RUN         = 2'd0;
  localparam logic [1:0] S_SW_INV      = 2'd1;
  localparam logic [1:0] S_SW_NEXT     = 2'd2;
  localparam logic [1:0] S_RELOAD_WAIT = 2'd3;

  logic [1:0]            r_state;
  switch_t               r_pend;
  logic                  r_invalidate;
  logic                  r_instr_wait;
  logic                  r_executed;
  logic                  r_next_thread;
  logic                  r_jump;
  logic [IADDR_LEN-1:0]  r_jump_addr;
  logic                  r_exec_valid;
  logic [INSTR_LEN-1:0]  r_exec_op;
  logic                  r_thread_done;
  logic                  r_err;

  logic [OPCODE_W-1:0]   w_op;
  logic [IADDR_LEN-1:0]  w_addr;
  logic [CNT_WIDTH-1:0]  w_imm;
  logic                  w_decode;
  logic                  w_in_switch;
  logic                  w_cnt_zero;
  logic                  w_cnt_set;
  logic                  w_cnt_dec;
  logic                  w_start_sw;
  switch_t               w_sw;
  logic                  w_executed;
  logic                  w_instr_wait;
  logic                  w_exec_valid;
  logic                  w_err_set;

  assign w_op   = bus.instruction[OPCODE_MSB -: OPCODE_W];
  assign w_addr = bus.instruction[IADDR_LEN-1:0];
  assign w_imm  = bus.instruction[CNT_WIDTH-1:0];

  // RELOAD_WAIT decodes exactly like RUN; it only marks that the fetch
  // pipeline is refilling after a switch.
  assign w_decode    = bus.instr_valid && (r_state == S_RUN || r_state == S_RELOAD_WAIT);
  assign w_in_switch = (r_state == S_SW_INV) || (r_state == S_SW_NEXT);

  thread_loop_cnt #(
    .N_THREADS (N_THREADS),
    .THREAD_W  (N_THREADS_MSB + 1),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_loop_cnt (
    .CLK       (CLK),
    .i_thread  (bus.thread_num),
    .i_set     (w_cnt_set && RESET_N),
    .i_set_val (w_imm),
    .i_dec     (w_cnt_dec && RESET_N),
    .o_zero    (w_cnt_zero)
  );

  always_comb begin
    w_cnt_set    = 1'b0;
    w_cnt_dec    = 1'b0;
    w_start_sw   = 1'b0;
    w_sw         = '0;
    w_executed   = 1'b0;
    w_instr_wait = 1'b0;
    w_exec_valid = 1'b0;
    w_err_set    = 1'b0;
    if (w_decode) begin
      case (w_op)
        OP_NOP: w_executed = 1'b1;
        OP_EXEC: begin
          if (bus.core_rdy) begin
            w_exec_valid = 1'b1;
            w_executed   = 1'b1;
          end else begin
            // Fetch re-presents the same instruction until the core accepts it.
            w_instr_wait = 1'b1;
          end
        end
        OP_SETCNT: begin
          w_cnt_set  = 1'b1;
          w_executed = 1'b1;
        end
        OP_LOOP: begin
          if (!w_cnt_zero) begin
            w_cnt_dec  = 1'b1;
            w_start_sw = 1'b1;
            w_sw.jump  = 1'b1;
            w_sw.addr  = w_addr;
          end else begin
            w_executed = 1'b1;
          end
        end
        OP_JMP: begin
          w_start_sw = 1'b1;
          w_sw.jump  = 1'b1;
          w_sw.addr  = w_addr;
        end
        OP_YIELD: begin
          w_start_sw    = 1'b1;
          w_sw.executed = 1'b1;
        end
        OP_HALT: begin
          w_start_sw = 1'b1;
          w_sw.jump  = 1'b1;
          w_sw.addr  = w_addr;
          w_sw.done  = 1'b1;
        end
        default: begin
          w_executed = 1'b1;
          w_err_set  = 1'b1;
        end
      endcase
    end
    // Fetch must stall while the pipeline is being flushed.
    if (bus.instr_valid && w_in_switch) begin
      w_err_set = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state       <= S_RUN;
      r_pend        <= '0;
      r_invalidate  <= 1'b0;
      r_instr_wait  <= 1'b0;
      r_executed    <= 1'b0;
      r_next_thread <= 1'b0;
      r_jump        <= 1'b0;
      r_jump_addr   <= '0;
      r_exec_valid  <= 1'b0;
      r_exec_op     <= '0;
      r_thread_done <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      case (r_state)
        S_RUN, S_RELOAD_WAIT: begin
          if (w_start_sw) begin
            r_state <= S_SW_INV;
            r_pend  <= w_sw;
          end else if (w_decode) begin
            r_state <= S_RUN;
          end
        end
        S_SW_INV:  r_state <= S_SW_NEXT;
        S_SW_NEXT: r_state <= S_RELOAD_WAIT;
        default:   r_state <= S_RUN;
      endcase

      r_invalidate  <= w_start_sw;
      r_instr_wait  <= w_instr_wait;
      r_exec_valid  <= w_exec_valid;
      r_exec_op     <= w_exec_valid ? bus.instruction : '0;
      r_err         <= r_err | w_err_set;

      // The pending switch is presented in the cycle after INVALIDATE.
      r_next_thread <= (r_state == S_SW_INV);
      r_jump        <= (r_state == S_SW_INV) && r_pend.jump;
      r_jump_addr   <= ((r_state == S_SW_INV) && r_pend.jump) ? r_pend.addr : '0;
      r_executed    <= w_executed || ((r_state == S_SW_INV) && r_pend.executed);
      r_thread_done <= (r_state == S_SW_INV) && r_pend.done;
    end
  end

  assign bus.INVALIDATE  = r_invalidate;
  assign bus.INSTR_WAIT  = r_instr_wait;
  assign bus.EXECUTED    = r_executed;
  assign bus.NEXT_THREAD = r_next_thread;
  assign bus.JUMP        = r_jump;
  assign bus.jump_addr   = r_jump_addr;
  assign bus.exec_valid  = r_exec_valid;
  assign bus.exec_op     = r_exec_op;
  assign bus.thread_done = r_thread_done;
  assign bus.err         = r_err;

endmodule

// File: tb/tb_instr_exec_ctrl.sv
// tb/tb_instr_exec_ctrl.sv - self-checking bench for instr_exec_ctrl
module tb_instr_exec_ctrl;
  import instr_exec_ctrl_pkg::*;

  typedef struct packed {
    logic        inv;
    logic        wt;
    logic        exe;
    logic        nxt;
    logic        jmp;
    logic [9:0]  ja;
    logic        ev;
    logic [15:0] eop;
    logic        done;
    logic        err;
  } out_t;

  logic CLK;
  logic RESET_N;
  int   n_checks;
  int   n_fails;

  instr_exec_ctrl_if #(.N_THREADS_MSB(3)) bus ();

  instr_exec_ctrl dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: a decoded switch schedules its two output cycles ahead
  // and blocks decoding for those two cycles.
  out_t m_exp;
  out_t m_pend;
  bit   m_pend_v;
  int   m_busy;
  bit   m_err;
  bit   m_live;
  int   m_cnt [16];

  always @(posedge CLK) begin : model
    out_t       e;
    logic [2:0] op;
    int         th;
    bit         sw;
    out_t       s;
    e  = '0;
    s  = '0;
    sw = 1'b0;
    op = bus.instruction[15:13];
    th = int'(bus.thread_num);
    if (!RESET_N) begin
      m_err    = 1'b0;
      m_busy   = 0;
      m_pend_v = 1'b0;
    end else if (m_busy > 0) begin
      if (m_pend_v) begin
        e        = m_pend;
        m_pend_v = 1'b0;
      end
      if (bus.instr_valid) m_err = 1'b1;
      m_busy = m_busy - 1;
    end else if (bus.instr_valid) begin
      case (op)
        3'd0: e.exe = 1'b1;
        3'd1: begin
          if (bus.core_rdy) begin
            e.ev  = 1'b1;
            e.exe = 1'b1;
            e.eop = bus.instruction;
          end else e.wt = 1'b1;
        end
        3'd2: begin
          m_cnt[th] = int'(bus.instruction[7:0]);
          e.exe     = 1'b1;
        end
        3'd3: begin
          if (m_cnt[th] != 0) begin
            m_cnt[th] = m_cnt[th] - 1;
            sw = 1'b1; s.jmp = 1'b1; s.ja = bus.instruction[9:0];
          end else e.exe = 1'b1;
        end
        3'd4: begin sw = 1'b1; s.jmp = 1'b1; s.ja = bus.instruction[9:0]; end
        3'd5: begin sw = 1'b1; s.exe = 1'b1; end
        3'd6: begin sw = 1'b1; s.jmp = 1'b1; s.ja = bus.instruction[9:0]; s.done = 1'b1; end
        default: begin e.exe = 1'b1; m_err = 1'b1; end
      endcase
      if (sw) begin
        e.inv    = 1'b1;
        s.nxt    = 1'b1;
        m_pend   = s;
        m_pend_v = 1'b1;
        m_busy   = 2;
      end
    end
    e.err  = m_err;
    m_exp  = e;
    m_live = 1'b1;
  end

  function automatic out_t dut_out();
    out_t o;
    o.inv  = bus.INVALIDATE;
    o.wt   = bus.INSTR_WAIT;
    o.exe  = bus.EXECUTED;
    o.nxt  = bus.NEXT_THREAD;
    o.jmp  = bus.JUMP;
    o.ja   = bus.jump_addr;
    o.ev   = bus.exec_valid;
    o.eop  = bus.exec_op;
    o.done = bus.thread_done;
    o.err  = bus.err;
    return o;
  endfunction

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [12:0] low);
    return {op, low};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [15:0] ins, input logic [3:0] th, input logic rdy);
    bus.instr_valid = v;
    bus.instruction = ins;
    bus.thread_num  = th;
    bus.core_rdy    = rdy;
    @(negedge CLK);
  endtask

  task automatic idle();
    step(1'b0, 16'h0, 4'd0, 1'b0);
  endtask

  initial begin
    logic [15:0] ins;
    logic [2:0]  op;
    n_checks = 0;
    n_fails  = 0;
    m_live   = 1'b0;
    RESET_N  = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instruction = '0;
    bus.thread_num  = '0;
    bus.core_rdy    = 1'b0;

    fork
      forever begin
        @(negedge CLK);
        if (m_live) check("model_cmp", 64'(dut_out()), 64'(m_exp));
      end
    join_none

    idle();
    idle();
    check("reset_outputs", 64'(dut_out()), 64'h0);
    RESET_N = 1'b1;

    for (int t = 0; t < 16; t++) step(1'b1, mk(3'd2, 13'($urandom_range(0, 3))), 4'(t), 1'b0);
    idle();

    // Loop on thread 3: count 2 gives two taken loops then a fall-through.
    step(1'b1, mk(3'd2, 13'd2), 4'd3, 1'b0);
    check("setcnt_exe", 64'({bus.EXECUTED, bus.INVALIDATE}), 64'b10);
    for (int k = 0; k < 2; k++) begin
      step(1'b1, mk(3'd3, 13'd40), 4'd3, 1'b0);
      check("loop_inv", 64'({bus.INVALIDATE, bus.NEXT_THREAD, bus.EXECUTED}), 64'b100);
      idle();
      check("loop_jump", 64'({bus.NEXT_THREAD, bus.JUMP, bus.jump_addr, bus.EXECUTED}), 64'({2'b11, 10'd40, 1'b0}));
      idle();
      check("loop_quiet", 64'(dut_out()), 64'h0);
    end
    step(1'b1, mk(3'd3, 13'd40), 4'd3, 1'b0);
    check("loop_fallthru", 64'({bus.EXECUTED, bus.INVALIDATE, bus.NEXT_THREAD}), 64'b100);
    idle();

    // Jump to 150.
    step(1'b1, mk(3'd4, 13'd150), 4'd1, 1'b0);
    check("jmp_inv", 64'({bus.INVALIDATE, bus.NEXT_THREAD, bus.JUMP}), 64'b100);
    idle();
    check("jmp_next", 64'({bus.INVALIDATE, bus.NEXT_THREAD, bus.JUMP, bus.jump_addr}), 64'({3'b011, 10'd150}));
    idle();
    check("jmp_quiet", 64'(dut_out()), 64'h0);

    // Core stall for three cycles, then accepted.
    ins = mk(3'd1, 13'h0abc);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, ins, 4'd2, 1'b0);
      check("exec_wait", 64'({bus.INSTR_WAIT, bus.EXECUTED, bus.exec_valid}), 64'b100);
    end
    step(1'b1, ins, 4'd2, 1'b1);
    check("exec_issue", 64'({bus.INSTR_WAIT, bus.EXECUTED, bus.exec_valid, bus.exec_op}), 64'({3'b011, 16'h2abc}));
    idle();

    // Yield.
    step(1'b1, mk(3'd5, 13'd99), 4'd4, 1'b0);
    check("yield_inv", 64'(bus.INVALIDATE), 64'd1);
    idle();
    check("yield_next", 64'({bus.INVALIDATE, bus.NEXT_THREAD, bus.EXECUTED, bus.JUMP}), 64'b0110);
    idle();

    // Halt on thread 5 to address 0.
    step(1'b1, mk(3'd6, 13'd0), 4'd5, 1'b0);
    check("halt_inv", 64'({bus.INVALIDATE, bus.thread_done}), 64'b10);
    idle();
    check("halt_next", 64'({bus.NEXT_THREAD, bus.JUMP, bus.jump_addr, bus.thread_done}), 64'({2'b11, 10'd0, 1'b1}));
    idle();

    // Reset while in SW_INV abandons the switch.
    step(1'b1, mk(3'd4, 13'd77), 4'd0, 1'b0);
    check("rst_sw_inv", 64'(bus.INVALIDATE), 64'd1);
    RESET_N = 1'b0;
    idle();
    check("rst_sw_outs", 64'(dut_out()), 64'h0);
    RESET_N = 1'b1;
    idle();
    check("rst_no_next", 64'(dut_out()), 64'h0);

    // instr_valid during SW_INV raises a sticky err.
    step(1'b1, mk(3'd4, 13'd20), 4'd6, 1'b0);
    step(1'b1, mk(3'd0, 13'd0), 4'd6, 1'b0);
    check("err_set", 64'({bus.NEXT_THREAD, bus.err}), 64'b11);
    for (int k = 0; k < 3; k++) begin
      idle();
      check("err_sticky", 64'(bus.err), 64'd1);
    end
    step(1'b1, mk(3'd7, 13'd5), 4'd6, 1'b0);
    check("undef_op", 64'({bus.EXECUTED, bus.INVALIDATE, bus.err}), 64'b101);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      RESET_N = ($urandom_range(0, 199) != 0);
      op  = 3'($urandom_range(0, 7));
      ins = mk(op, 13'($urandom));
      if (op == 3'd2) ins[7:0] = 8'($urandom_range(0, 3));
      step($urandom_range(0, 3) != 0, ins, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end
    RESET_N = 1'b1;
    idle();
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/instr_exec_ctrl.md
Name: instr_exec_ctrl

Overview:
- Downstream control stage of the instruction fetch block in each sha512unit CPU.
- Consumes each fetched instruction and decodes its opcode.
- Drives the fetch-side control inputs: INVALIDATE, INSTR_WAIT, EXECUTED, NEXT_THREAD, JUMP, jump_addr.
- Owns per-thread loop counters and issues compute ops to the core.

Parameters:
- N_CORES, 4, number of SHA-512 cores.
- N_THREADS, 4*N_CORES, thread count.
- N_THREADS_MSB, `MSB(N_THREADS-1), thread index MSB.
- CNT_WIDTH, 8, loop counter width.

Ports:
- CLK  in  1  clock.
- RESET_N  in  1  synchronous active-low reset; one clock, reset is synchronous and active-low.
- instruction  in  `INSTR_LEN  fetched instruction.
- instr_valid  in  1  instruction valid this cycle (registered stage_allow[0]).
- thread_num  in  N_THREADS_MSB+1  currently executing thread.
- core_rdy  in  1  target core accepts a compute op.
- INVALIDATE  out  1  flush fetch pipeline.
- INSTR_WAIT  out  1  hold current instruction.
- EXECUTED  out  1  advance effective IP.
- NEXT_THREAD  out  1  switch thread.
- JUMP  out  1  load jump_addr into IP of thread_num.
- jump_addr  out  `IADDR_LEN  jump target.
- exec_valid  out  1  compute op issued.
- exec_op  out  `INSTR_LEN  issued instruction.
- thread_done  out  1  pulse: thread_num finished (HALT).
- err  out  1  sticky protocol error.

Behaviour:
- Fields:
  - opcode = instruction[`INSTR_LEN-1 -: 3]
  - addr = instruction[`IADDR_LEN-1:0]
  - imm = instruction[CNT_WIDTH-1:0]
- All outputs are registered. Response appears the cycle after instr_valid (latency 1).
- Reset: every output is 0 and the FSM goes to RUN. Reset mid-switch abandons the switch with no NEXT_THREAD. cnt_mem is not cleared.
- FSM states: RUN, SW_INV, SW_NEXT, RELOAD_WAIT.
- In RUN with instr_valid, by opcode:
  - OP_NOP: EXECUTED=1.
  - OP_EXEC:
    - If core_rdy: exec_valid=1, exec_op=instruction, EXECUTED=1.
    - Else: INSTR_WAIT=1, EXECUTED=0. The fetch stage re-presents the instruction (instr_valid again) and it is retried every cycle until core_rdy.
  - OP_SETCNT: cnt_mem[thread_num] <= imm; EXECUTED=1.
  - OP_LOOP:
    - If cnt_mem[thread_num] != 0: decrement it and take the jump path to addr.
    - Else: EXECUTED=1, fall through, no thread switch.
  - OP_JMP: take the jump path to addr.
  - OP_YIELD: switch path with JUMP=0 and EXECUTED=1.
  - OP_HALT: jump path to addr, plus thread_done=1 in the SW_NEXT cycle.
  - Undefined opcode: treated as NOP, and err set.
- Jump/switch path sequence:
  - RUN→SW_INV: INVALIDATE=1 for exactly one cycle.
  - SW_INV→SW_NEXT: NEXT_THREAD=1, with JUMP/jump_addr or EXECUTED as defined above, for exactly one cycle.
  - SW_NEXT→RELOAD_WAIT, then RELOAD_WAIT→RUN on the first instr_valid, which is decoded normally.
  - INVALIDATE always precedes NEXT_THREAD by exactly 1 cycle. JUMP is never asserted without NEXT_THREAD.
- instr_valid in SW_INV or SW_NEXT is ignored and sets err.
- INVALIDATE and INSTR_WAIT are never asserted together.
- Counter arithmetic: CNT_WIDTH-bit unsigned. Decrement happens only when the counter is nonzero, so it never wraps.
- cnt_mem: N_THREADS x CNT_WIDTH distributed RAM. Read is asynchronous by thread_num; write is on CLK.

Decomposition:
- sha512.vh gains:
  - opcode constants OP_NOP=0, OP_EXEC=1, OP_SETCNT=2, OP_LOOP=3, OP_JMP=4, OP_YIELD=5, OP_HALT=6;
  - OPCODE_MSB and the field offsets.
- One sub-module, thread_loop_cnt: per-thread counter RAM with set/decrement/zero-flag.

Test Plan:
- Thread 3, SETCNT imm=2, then LOOP addr=40 presented three times → LOOP #1: jump path to 40, counter 1. LOOP #2: jump path to 40, counter 0. LOOP #3: EXECUTED only, counter stays 0.
- JMP addr=150 at cycle t → INVALIDATE at t+1; NEXT_THREAD=JUMP=1 with jump_addr=150 at t+2; all low at t+3.
- OP_EXEC with core_rdy=0 for 3 cycles, then 1 → INSTR_WAIT=1 on 3 cycles, then exec_valid=1 and EXECUTED=1 once, with exec_op equal to the input instruction.
- YIELD → INVALIDATE, then NEXT_THREAD=1, EXECUTED=1, JUMP=0.
- HALT addr=0 on thread 5 → thread_done=1 in the NEXT_THREAD cycle with JUMP=1 and jump_addr=0.
- RESET_N=0 during SW_INV → next cycle all outputs 0, no NEXT_THREAD. Separately, instr_valid during SW_INV → err=1 and stays 1.
